// File: rtl/sr_cmd_driver_pkg.sv
// Shared types and constants for the SR flip-flop command driver.
package sr_cmd_driver_pkg;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Registered drive/status outputs of the driver
  typedef struct packed {
    logic s;
    logic r;
    logic busy;
    logic done;
    logic err;
  } drv_out_t;

endpackage

// File: rtl/sr_cmd_driver_if.sv
// Command handshake plus SR cell drive/feedback bundle.
interface sr_cmd_driver_if;

  logic cmd_valid;
  logic cmd_value;
  logic cmd_ready;
  logic s;
  logic r;
  logic q_fb;
  logic busy;
  logic done;
  logic err;

  modport master (
    output cmd_valid, cmd_value, q_fb,
    input  cmd_ready, s, r, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_value, q_fb,
    output cmd_ready, s, r, busy, done, err
  );

endinterface

// File: rtl/sr_cmd_driver_cycle_down_counter.sv
// Loadable down-counter with zero flag; times both the pulse and the settle window.
module cycle_down_counter
  import sr_cmd_driver_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] count;

  // Load wins over decrement; decrement saturates at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/sr_cmd_driver.sv
// Writes a requested value into an SR cell with a timed set/reset pulse,
// waits a settle window and reports whether the fed-back q matched.
module sr_cmd_driver
  import sr_cmd_driver_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  sr_cmd_driver_if.slave  bus
);

  if ((PULSE_CYCLES < 1) || (PULSE_CYCLES > CNT_MAX)) begin : g_bad_pulse
    $error("sr_cmd_driver: PULSE_CYCLES must be in 1..255");
  end
  if (SETTLE_CYCLES > CNT_MAX) begin : g_bad_settle
    $error("sr_cmd_driver: SETTLE_CYCLES must be in 0..255");
  end

  localparam logic [CNT_W-1:0] P_LOAD     = CNT_W'(PULSE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] S_LOAD     = CNT_W'(SETTLE_CYCLES - 32'd1);
  localparam bit               HAS_SETTLE = (SETTLE_CYCLES != 0);

  state_e           state;
  state_e           state_nxt;
  logic             target;
  logic             target_nxt;
  logic             err_nxt;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero_c;
  logic             cmd_ready_c;
  logic             accept_c;
  drv_out_t         out_q;

  cycle_down_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero_c)
  );

  assign cmd_ready_c = (state == ST_IDLE) && !rst;
  assign accept_c    = bus.cmd_valid && cmd_ready_c;

  // State and target register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      target <= 1'b0;
    end else begin
      state  <= state_nxt;
      target <= target_nxt;
    end
  end

  // Next-state, counter control and the err value captured on entry to DONE
  always_comb begin
    state_nxt    = state;
    target_nxt   = target;
    err_nxt      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          target_nxt = bus.cmd_value;
          if (bus.q_fb == bus.cmd_value) begin
            state_nxt = ST_DONE;
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = P_LOAD;
            state_nxt    = ST_PULSE;
          end
        end
      end
      ST_PULSE: begin
        if (!cnt_zero_c) begin
          cnt_dec = 1'b1;
        end else if (HAS_SETTLE) begin
          cnt_load     = 1'b1;
          cnt_load_val = S_LOAD;
          state_nxt    = ST_SETTLE;
        end else begin
          state_nxt = ST_DONE;
          err_nxt   = (bus.q_fb != target);
        end
      end
      ST_SETTLE: begin
        if (!cnt_zero_c) begin
          cnt_dec = 1'b1;
        end else begin
          state_nxt = ST_DONE;
          err_nxt   = (bus.q_fb != target);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs registered from next state so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q.s    <= (state_nxt == ST_PULSE) &&  target_nxt;
      out_q.r    <= (state_nxt == ST_PULSE) && !target_nxt;
      out_q.busy <= (state_nxt != ST_IDLE);
      out_q.done <= (state_nxt == ST_DONE);
      out_q.err  <= err_nxt;
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.s         = out_q.s;
  assign bus.r         = out_q.r;
  assign bus.busy      = out_q.busy;
  assign bus.done      = out_q.done;
  assign bus.err       = out_q.err;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Scoreboard bench: two driver configurations, each writing a behavioural SR cell.
module tb_sr_cmd_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  logic q_a = 1'b0;
  logic q_b = 1'b0;
  logic stuck_a = 1'b0;
  int   cyc = 0;

  sr_cmd_driver_if bus_a ();
  sr_cmd_driver_if bus_b ();

  sr_cmd_driver #(.PULSE_CYCLES(2), .SETTLE_CYCLES(3)) dut_a (
    .clk (clk), .rst (rst_a), .bus (bus_a)
  );
  sr_cmd_driver #(.PULSE_CYCLES(1), .SETTLE_CYCLES(0)) dut_b (
    .clk (clk), .rst (rst_b), .bus (bus_b)
  );

  // SR cells; stuck_a clamps cell A to 0
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stuck_a)      q_a <= 1'b0;
    else if (bus_a.s) q_a <= 1'b1;
    else if (bus_a.r) q_a <= 1'b0;
    if (bus_b.s)      q_b <= 1'b1;
    else if (bus_b.r) q_b <= 1'b0;
  end
  assign bus_a.q_fb = q_a;
  assign bus_b.q_fb = q_b;

  typedef struct {
    int   done_cyc;
    logic err;
    int   s_cnt;
    int   r_cnt;
  } exp_t;

  exp_t expq_a[$];
  exp_t expq_b[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   sr_viol = 0;
  int   s_cnt[2];
  int   r_cnt[2];
  bit   pend_rdy[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, want, cyc);
  endtask

  // Monitor: accumulate pulse lengths and compare against the scoreboard on each done
  task automatic mon(input int id, input logic rst, input logic done, input logic err,
                     input logic s, input logic r, input logic ready, input logic busy);
    exp_t e;
    bit   have;
    if (s && r) sr_viol++;
    if (rst) begin
      s_cnt[id] = 0; r_cnt[id] = 0; pend_rdy[id] = 0;
      return;
    end
    if (pend_rdy[id]) begin
      chk($sformatf("ready_after_done_%0d", id), 32'(ready), 32'd1);
      chk($sformatf("idle_after_done_%0d", id), 32'(busy), 32'd0);
      pend_rdy[id] = 0;
    end
    if (s) s_cnt[id]++;
    if (r) r_cnt[id]++;
    if (done) begin
      have = (id == 0) ? (expq_a.size() != 0) : (expq_b.size() != 0);
      if (!have) begin
        chk($sformatf("unexpected_done_%0d", id), 32'd1, 32'd0);
      end else begin
        if (id == 0) e = expq_a.pop_front();
        else         e = expq_b.pop_front();
        chk($sformatf("done_cycle_%0d", id), 32'(cyc), 32'(e.done_cyc));
        chk($sformatf("err_%0d", id), 32'(err), 32'(e.err));
        chk($sformatf("s_len_%0d", id), 32'(s_cnt[id]), 32'(e.s_cnt));
        chk($sformatf("r_len_%0d", id), 32'(r_cnt[id]), 32'(e.r_cnt));
      end
      s_cnt[id] = 0; r_cnt[id] = 0; pend_rdy[id] = 1;
    end
  endtask

  always @(negedge clk) begin
    mon(0, rst_a, bus_a.done, bus_a.err, bus_a.s, bus_a.r, bus_a.cmd_ready, bus_a.busy);
    mon(1, rst_b, bus_b.done, bus_b.err, bus_b.s, bus_b.r, bus_b.cmd_ready, bus_b.busy);
  end

  // Issue one command to DUT A; write path done lands P+S = 5 cycles after cycle 1
  task automatic issue(input logic val, input bit exp_skip, input logic exp_err, input bit push);
    int   n = 0;
    exp_t e;
    while (!bus_a.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready_a", 32'(bus_a.cmd_ready), 32'd1);
    bus_a.cmd_valid = 1'b1;
    bus_a.cmd_value = val;
    e.done_cyc = cyc + 1 + (exp_skip ? 0 : 5);
    e.err      = exp_err;
    e.s_cnt    = (!exp_skip &&  val) ? 2 : 0;
    e.r_cnt    = (!exp_skip && !val) ? 2 : 0;
    if (push) expq_a.push_back(e);
    @(negedge clk);
    bus_a.cmd_valid = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while (expq_a.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_a", 32'(expq_a.size()), 32'd0);
    @(negedge clk);
  endtask

  // Directed vectors for DUT A: value, expected skip, expected err
  typedef struct { logic val; bit skip; logic err; } vec_t;
  vec_t vecs[5] = '{
    '{1'b1, 1'b0, 1'b0},   // q=0 -> set pulse, cell follows
    '{1'b0, 1'b0, 1'b0},   // q=1 -> reset pulse
    '{1'b1, 1'b0, 1'b0},   // q=0 -> set again
    '{1'b1, 1'b1, 1'b0},   // q=1 already -> skip
    '{1'b0, 1'b0, 1'b0}    // q=1 -> reset
  };

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    bit   skip;
    exp_t e;
    s_cnt = '{0, 0}; r_cnt = '{0, 0}; pend_rdy = '{0, 0};
    bus_a.cmd_valid = 1'b0; bus_a.cmd_value = 1'b0;
    bus_b.cmd_valid = 1'b0; bus_b.cmd_value = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready_a", 32'(bus_a.cmd_ready), 32'd0);
    chk("rst_outs_a", 32'({bus_a.s, bus_a.r, bus_a.busy, bus_a.done, bus_a.err}), 32'd0);
    chk("rst_ready_b", 32'(bus_b.cmd_ready), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("idle_ready_a", 32'(bus_a.cmd_ready), 32'd1);
    chk("idle_busy_a", 32'(bus_a.busy), 32'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].val, vecs[i].skip, vecs[i].err, 1'b1);
      drain_a();
    end

    // Cell stuck at 0: set pulse has no effect, err expected
    stuck_a = 1'b1;
    @(negedge clk);
    issue(1'b1, 1'b0, 1'b1, 1'b1);
    drain_a();
    stuck_a = 1'b0;

    // Async reset in cycle 2 of a write: abandoned, no done
    issue(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_a = 1'b1;
    #1;
    chk("abort_s", 32'(bus_a.s), 32'd0);
    chk("abort_busy", 32'(bus_a.busy), 32'd0);
    chk("abort_done", 32'(bus_a.done), 32'd0);
    chk("abort_ready", 32'(bus_a.cmd_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus_a.cmd_ready), 32'd1);
    // Cell latched the first pulse cycle, so q=1 and a reset write follows
    issue(1'b0, 1'b0, 1'b0, 1'b1);
    drain_a();

    // DUT B, P=1 S=0, valid held high with random values. The cell latches s/r
    // on the same edge that enters DONE, so a write always reports err.
    bus_b.cmd_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bus_b.cmd_value = 1'($urandom_range(0, 1));
      if (bus_b.cmd_ready) begin
        skip       = (q_b == bus_b.cmd_value);
        e.done_cyc = cyc + 1 + (skip ? 0 : 1);
        e.err      = !skip;
        e.s_cnt    = (!skip &&  bus_b.cmd_value) ? 1 : 0;
        e.r_cnt    = (!skip && !bus_b.cmd_value) ? 1 : 0;
        expq_b.push_back(e);
      end
      @(negedge clk);
    end
    bus_b.cmd_valid = 1'b0;
    n = 0;
    while (expq_b.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_b", 32'(expq_b.size()), 32'd0);
    @(negedge clk);

    chk("sr_exclusive", 32'(sr_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
